// File: rtl/su51e8gf_pkg.sv
// Shared constants for the SFP I2C scheduler: FSM states, engine command codes,
// poll target and the engine start/done timeouts.
package su51e8gf_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_ISSUE      = 3'd1,
        ST_WAIT_START = 3'd2,
        ST_WAIT_DONE  = 3'd3,
        ST_COMPLETE   = 3'd4
    } state_t;

    localparam logic [1:0]  CMD_IDLE  = 2'b00;
    localparam logic [1:0]  CMD_WR    = 2'b01;
    localparam logic [1:0]  CMD_RD    = 2'b10;

    localparam logic [6:0]  POLL_DEV  = 7'h51;
    localparam logic [7:0]  POLL_ADDR = 8'h60;
    localparam int unsigned START_TO  = 16;
    localparam logic [19:0] DONE_TO   = 20'hFFFFF;

    localparam logic [2:0]  PORT_LAST = 3'd7;

    function automatic logic [7:0] onehot8(input logic [2:0] idx);
        return 8'h01 << idx;
    endfunction

endpackage

// File: rtl/sfp_poll_ptr.sv
// Poll round tracker: round-active flag plus port pointer; absent ports are
// skipped one per cycle while the scheduler is idle, present ports raise req_o.
module sfp_poll_ptr
    import su51e8gf_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick_i,
    input  logic [7:0] absent_i,
    input  logic       skip_en_i,
    input  logic       adv_i,
    output logic       req_o,
    output logic [2:0] ptr_o
);

    logic       act_q, act_d;
    logic [2:0] ptr_q, ptr_d;
    logic       cur_absent;
    logic       step;

    assign cur_absent = absent_i[ptr_q];
    // Presence is only evaluated while idle, so a port vanishing mid-transaction still completes.
    assign step       = act_q && ((cur_absent && skip_en_i) || adv_i);

    always_comb begin
        act_d = act_q;
        ptr_d = ptr_q;
        if (tick_i && !act_q) begin
            act_d = 1'b1;
            ptr_d = 3'd0;
        end else if (step) begin
            if (ptr_q == PORT_LAST) begin
                act_d = 1'b0;
            end else begin
                ptr_d = ptr_q + 3'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act_q <= 1'b0;
            ptr_q <= 3'd0;
        end else begin
            act_q <= act_d;
            ptr_q <= ptr_d;
        end
    end

    assign req_o = act_q && !cur_absent;
    assign ptr_o = ptr_q;

endmodule

// File: rtl/sfp_iic_sched.sv
// Arbitrates CPU requests and periodic temperature polls onto one I2C engine,
// with start/done timeouts; results appear one cycle after the engine drops busy.
module sfp_iic_sched
    import su51e8gf_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cpu_req,
    input  logic [2:0]  cpu_port,
    input  logic [1:0]  cpu_cmd,
    input  logic [6:0]  cpu_dev_id,
    input  logic [7:0]  cpu_add,
    input  logic [15:0] cpu_wdata,
    output logic        cpu_busy,
    output logic        cpu_done,
    output logic        cpu_fail,
    output logic [15:0] cpu_rdata,
    input  logic        poll_tick,
    input  logic [7:0]  sfp_only_reg,
    output logic        poll_valid,
    output logic [2:0]  poll_port,
    output logic [15:0] poll_data,
    output logic        poll_fail,
    output logic [1:0]  command,
    output logic [6:0]  dev_id,
    output logic [7:0]  add,
    output logic [15:0] data_out,
    output logic [7:0]  iic_sel,
    input  logic        busy,
    input  logic        fail,
    input  logic [15:0] data_in
);

    localparam logic [4:0]  ST_LAST = 5'(START_TO - 1);
    localparam logic [19:0] DN_LAST = DONE_TO - 20'd1;

    state_t      state_q, state_d;
    logic        cpu_busy_q, cpu_pend_q;
    logic [2:0]  cpu_port_q;
    logic [1:0]  cpu_cmd_q;
    logic [6:0]  cpu_dev_q;
    logic [7:0]  cpu_add_q;
    logic [15:0] cpu_wdata_q;
    logic        own_cpu_q, own_cpu_d;
    logic [2:0]  port_q, port_d;
    logic [1:0]  cmd_q, cmd_d;
    logic [6:0]  dev_q, dev_d;
    logic [7:0]  add_q, add_d;
    logic [15:0] wdat_q, wdat_d;
    logic [7:0]  sel_q, sel_d;
    logic [4:0]  st_cnt_q, st_cnt_d;
    logic [19:0] dn_cnt_q, dn_cnt_d;
    logic        res_fail_d;
    logic [15:0] res_data_d;
    logic        cpu_done_q, cpu_fail_q, poll_valid_q, poll_fail_q;
    logic [15:0] cpu_rdata_q, poll_data_q;
    logic [2:0]  poll_port_q;
    logic        poll_req, take_cpu, poll_adv;
    logic [2:0]  poll_ptr;

    assign poll_adv = (state_q == ST_COMPLETE) && !own_cpu_q;

    sfp_poll_ptr u_poll_ptr (
        .clk       (clk),
        .rst_n     (rst_n),
        .tick_i    (poll_tick),
        .absent_i  (sfp_only_reg),
        .skip_en_i (state_q == ST_IDLE),
        .adv_i     (poll_adv),
        .req_o     (poll_req),
        .ptr_o     (poll_ptr)
    );

    always_comb begin
        state_d    = state_q;
        own_cpu_d  = own_cpu_q;
        port_d     = port_q;
        cmd_d      = cmd_q;
        dev_d      = dev_q;
        add_d      = add_q;
        wdat_d     = wdat_q;
        st_cnt_d   = 5'd0;
        dn_cnt_d   = 20'd0;
        res_fail_d = 1'b0;
        res_data_d = 16'h0000;
        take_cpu   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cpu_pend_q) begin
                    take_cpu  = 1'b1;
                    own_cpu_d = 1'b1;
                    port_d    = cpu_port_q;
                    cmd_d     = cpu_cmd_q;
                    dev_d     = cpu_dev_q;
                    add_d     = cpu_add_q;
                    wdat_d    = cpu_wdata_q;
                    // Malformed commands never reach the engine.
                    if (cpu_cmd_q == CMD_WR || cpu_cmd_q == CMD_RD) begin
                        state_d = ST_ISSUE;
                    end else begin
                        state_d    = ST_COMPLETE;
                        res_fail_d = 1'b1;
                    end
                end else if (poll_req) begin
                    own_cpu_d = 1'b0;
                    port_d    = poll_ptr;
                    cmd_d     = CMD_RD;
                    dev_d     = POLL_DEV;
                    add_d     = POLL_ADDR;
                    wdat_d    = 16'h0000;
                    state_d   = ST_ISSUE;
                end
            end
            ST_ISSUE: state_d = ST_WAIT_START;
            ST_WAIT_START: begin
                if (busy) begin
                    state_d = ST_WAIT_DONE;
                end else if (st_cnt_q == ST_LAST) begin
                    state_d    = ST_COMPLETE;
                    res_fail_d = 1'b1;
                end else begin
                    st_cnt_d = st_cnt_q + 5'd1;
                end
            end
            ST_WAIT_DONE: begin
                if (!busy) begin
                    state_d    = ST_COMPLETE;
                    res_fail_d = fail;
                    res_data_d = data_in;
                end else if (dn_cnt_q == DN_LAST) begin
                    state_d    = ST_COMPLETE;
                    res_fail_d = 1'b1;
                end else begin
                    dn_cnt_d = dn_cnt_q + 20'd1;
                end
            end
            ST_COMPLETE: state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
        sel_d = sel_q;
        if (state_d == ST_ISSUE) begin
            sel_d = onehot8(port_d);
        end else if (state_d == ST_IDLE) begin
            sel_d = 8'h00;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cpu_busy_q   <= 1'b0;
            cpu_pend_q   <= 1'b0;
            cpu_port_q   <= 3'd0;
            cpu_cmd_q    <= CMD_IDLE;
            cpu_dev_q    <= 7'd0;
            cpu_add_q    <= 8'd0;
            cpu_wdata_q  <= 16'd0;
            own_cpu_q    <= 1'b0;
            port_q       <= 3'd0;
            cmd_q        <= CMD_IDLE;
            dev_q        <= 7'd0;
            add_q        <= 8'd0;
            wdat_q       <= 16'd0;
            sel_q        <= 8'h00;
            st_cnt_q     <= 5'd0;
            dn_cnt_q     <= 20'd0;
            cpu_done_q   <= 1'b0;
            cpu_fail_q   <= 1'b0;
            cpu_rdata_q  <= 16'd0;
            poll_valid_q <= 1'b0;
            poll_port_q  <= 3'd0;
            poll_data_q  <= 16'd0;
            poll_fail_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            own_cpu_q <= own_cpu_d;
            port_q    <= port_d;
            cmd_q     <= cmd_d;
            dev_q     <= dev_d;
            add_q     <= add_d;
            wdat_q    <= wdat_d;
            sel_q     <= sel_d;
            st_cnt_q  <= st_cnt_d;
            dn_cnt_q  <= dn_cnt_d;
            if (cpu_req && !cpu_busy_q) begin
                cpu_busy_q  <= 1'b1;
                cpu_pend_q  <= 1'b1;
                cpu_port_q  <= cpu_port;
                cpu_cmd_q   <= cpu_cmd;
                cpu_dev_q   <= cpu_dev_id;
                cpu_add_q   <= cpu_add;
                cpu_wdata_q <= cpu_wdata;
            end else begin
                if (take_cpu) cpu_pend_q <= 1'b0;
                if (state_q == ST_COMPLETE && own_cpu_q) cpu_busy_q <= 1'b0;
            end
            cpu_done_q   <= (state_d == ST_COMPLETE) && own_cpu_d;
            poll_valid_q <= (state_d == ST_COMPLETE) && !own_cpu_d;
            if (state_d == ST_COMPLETE) begin
                if (own_cpu_d) begin
                    cpu_fail_q  <= res_fail_d;
                    cpu_rdata_q <= res_data_d;
                end else begin
                    poll_port_q <= port_d;
                    poll_fail_q <= res_fail_d;
                    poll_data_q <= res_data_d;
                end
            end
        end
    end

    assign command    = (state_q == ST_ISSUE) ? cmd_q : CMD_IDLE;
    assign dev_id     = dev_q;
    assign add        = add_q;
    assign data_out   = wdat_q;
    assign iic_sel    = sel_q;
    assign cpu_busy   = cpu_busy_q;
    assign cpu_done   = cpu_done_q;
    assign cpu_fail   = cpu_fail_q;
    assign cpu_rdata  = cpu_rdata_q;
    assign poll_valid = poll_valid_q;
    assign poll_port  = poll_port_q;
    assign poll_data  = poll_data_q;
    assign poll_fail  = poll_fail_q;

endmodule

// File: tb/tb_sfp_iic_sched.sv
// Directed bench for sfp_iic_sched: an engine model answers reads with 16'h1A00+port,
// and a scoreboard of expected issues/results is checked every cycle.
module tb_sfp_iic_sched;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cpu_req;
    logic [2:0]  cpu_port;
    logic [1:0]  cpu_cmd;
    logic [6:0]  cpu_dev_id;
    logic [7:0]  cpu_add;
    logic [15:0] cpu_wdata;
    logic        cpu_busy, cpu_done, cpu_fail;
    logic [15:0] cpu_rdata;
    logic        poll_tick;
    logic [7:0]  sfp_only_reg;
    logic        poll_valid, poll_fail;
    logic [2:0]  poll_port;
    logic [15:0] poll_data;
    logic [1:0]  command;
    logic [6:0]  dev_id;
    logic [7:0]  add;
    logic [15:0] data_out;
    logic [7:0]  iic_sel;
    logic        busy, fail;
    logic [15:0] data_in;

    sfp_iic_sched dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(cpu_req), .cpu_port(cpu_port), .cpu_cmd(cpu_cmd), .cpu_dev_id(cpu_dev_id),
        .cpu_add(cpu_add), .cpu_wdata(cpu_wdata), .cpu_busy(cpu_busy), .cpu_done(cpu_done),
        .cpu_fail(cpu_fail), .cpu_rdata(cpu_rdata),
        .poll_tick(poll_tick), .sfp_only_reg(sfp_only_reg), .poll_valid(poll_valid),
        .poll_port(poll_port), .poll_data(poll_data), .poll_fail(poll_fail),
        .command(command), .dev_id(dev_id), .add(add), .data_out(data_out), .iic_sel(iic_sel),
        .busy(busy), .fail(fail), .data_in(data_in)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  cmd;
        logic [6:0]  dev;
        logic [7:0]  add;
        logic [15:0] wd;
        logic [7:0]  sel;
    } iss_t;

    typedef struct {
        logic [2:0]  port;
        logic [15:0] data;
        logic        fail;
    } res_t;

    iss_t exp_iss[$];
    res_t exp_poll[$];
    res_t exp_cpu[$];
    logic [2:0] seen_ports[$];

    int checks = 0;
    int errs   = 0;
    int cyc    = 0;
    int n_poll = 0, n_cpu = 0, n_cmd = 0;
    int cmd_cyc = 0, done_cyc = 0, fall_cyc = 0;
    logic [15:0] first_pdata, last_pdata;

    // Engine model controls
    logic eng_dead = 1'b0;
    int   e_len    = 4;
    int   e_ph     = 0;
    int   e_cnt    = 0;
    logic [1:0] e_cmd;
    logic [2:0] e_port;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [2:0] sel2idx(input logic [7:0] s);
        logic [2:0] r = 3'd0;
        for (int i = 0; i < 8; i++) if (s[i]) r = 3'(i);
        return r;
    endfunction

    always @(posedge clk) cyc++;

    // Engine: busy rises two cycles after a command, stays up e_len cycles, then drops with data.
    always @(negedge clk) begin
        if (!rst_n) begin
            busy    = 1'b0;
            fail    = 1'b0;
            data_in = 16'h0000;
            e_ph    = 0;
        end else if (e_ph == 0) begin
            if (command != 2'b00 && !eng_dead) begin
                e_ph   = 1;
                e_cnt  = 2;
                e_cmd  = command;
                e_port = sel2idx(iic_sel);
            end
        end else if (e_ph == 1) begin
            e_cnt--;
            if (e_cnt == 0) begin
                busy  = 1'b1;
                e_ph  = 2;
                e_cnt = e_len;
            end
        end else begin
            e_cnt--;
            if (e_cnt == 0) begin
                busy     = 1'b0;
                fail     = 1'b0;
                data_in  = (e_cmd == 2'b10) ? (16'h1A00 + 16'(e_port)) : 16'h0000;
                e_ph     = 0;
                fall_cyc = cyc;
            end
        end
    end

    // Scoreboard compare
    always @(negedge clk) begin
        iss_t ei;
        res_t er;
        if (rst_n) begin
            chk("sel_onehot0", 32'($onehot0(iic_sel)), 32'd1);
            if (command != 2'b00) begin
                n_cmd++;
                cmd_cyc = cyc;
                if (exp_iss.size() == 0) begin
                    chk("unexpected_cmd", 32'(command), 32'd0);
                end else begin
                    ei = exp_iss.pop_front();
                    chk("iss_cmd", 32'(command), 32'(ei.cmd));
                    chk("iss_dev", 32'(dev_id), 32'(ei.dev));
                    chk("iss_add", 32'(add), 32'(ei.add));
                    chk("iss_sel", 32'(iic_sel), 32'(ei.sel));
                    if (ei.cmd == 2'b01) chk("iss_wdata", 32'(data_out), 32'(ei.wd));
                end
            end
            if (poll_valid) begin
                n_poll++;
                seen_ports.push_back(poll_port);
                if (n_poll == 1) first_pdata = poll_data;
                last_pdata = poll_data;
                if (exp_poll.size() == 0) begin
                    chk("unexpected_poll", 32'(poll_valid), 32'd0);
                end else begin
                    er = exp_poll.pop_front();
                    chk("poll_port", 32'(poll_port), 32'(er.port));
                    chk("poll_data", 32'(poll_data), 32'(er.data));
                    chk("poll_fail", 32'(poll_fail), 32'(er.fail));
                    if (!er.fail) chk("poll_latency", 32'(cyc - fall_cyc), 32'd1);
                end
            end
            if (cpu_done) begin
                n_cpu++;
                done_cyc = cyc;
                if (exp_cpu.size() == 0) begin
                    chk("unexpected_cpu_done", 32'(cpu_done), 32'd0);
                end else begin
                    er = exp_cpu.pop_front();
                    chk("cpu_fail", 32'(cpu_fail), 32'(er.fail));
                    chk("cpu_rdata", 32'(cpu_rdata), 32'(er.data));
                    if (!er.fail) chk("cpu_latency", 32'(cyc - fall_cyc), 32'd1);
                end
            end
        end
    end

    task automatic push_round(input logic [7:0] absent, input int from, input int to);
        for (int p = from; p <= to; p++) begin
            if (!absent[p]) begin
                logic [7:0] s = 8'h01 << p;
                exp_iss.push_back('{2'b10, 7'h51, 8'h60, 16'h0000, s});
                exp_poll.push_back('{3'(p), 16'h1A00 + 16'(p), 1'b0});
            end
        end
    endtask

    task automatic tick();
        @(negedge clk) poll_tick = 1'b1;
        @(negedge clk) poll_tick = 1'b0;
    endtask

    task automatic cpu(input logic [2:0] p, input logic [1:0] c, input logic [6:0] d,
                       input logic [7:0] a, input logic [15:0] w);
        @(negedge clk);
        cpu_port = p; cpu_cmd = c; cpu_dev_id = d; cpu_add = a; cpu_wdata = w;
        cpu_req = 1'b1;
        @(negedge clk);
        cpu_req = 1'b0;
        chk("cpu_busy_set", 32'(cpu_busy), 32'd1);
    endtask

    task automatic run(input int budget);
        int n = 0;
        while ((exp_iss.size() != 0 || exp_poll.size() != 0 || exp_cpu.size() != 0 || cpu_busy)
               && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("drain_in_budget", 32'(n < budget), 32'd1);
        if (n >= budget) begin
            exp_iss.delete(); exp_poll.delete(); exp_cpu.delete();
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic wait_sel(input logic [7:0] s, input int budget);
        int n = 0;
        while (iic_sel != s && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("wait_sel", 32'(iic_sel), 32'(s));
    endtask

    task automatic wait_busy(input int budget);
        int n = 0;
        while (!busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("wait_busy", 32'(busy), 32'd1);
    endtask

    initial begin
        int snap_poll, snap_cpu, snap_cmd;
        rst_n = 1'b0; cpu_req = 1'b0; cpu_port = 3'd0; cpu_cmd = 2'b00; cpu_dev_id = 7'd0;
        cpu_add = 8'd0; cpu_wdata = 16'd0; poll_tick = 1'b0; sfp_only_reg = 8'h00;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_cmd_sel", 32'({command, iic_sel}), 32'd0);
        chk("rst_flags", 32'({cpu_busy, cpu_done, poll_valid, cpu_fail, poll_fail, poll_port}), 32'd0);
        chk("rst_data", {cpu_rdata, poll_data}, 32'd0);
        chk("rst_eng", 32'({dev_id, add, data_out}), 32'd0);

        // All ports present: eight reads in port order
        push_round(8'h00, 0, 7);
        tick();
        run(2000);
        chk("round_count", 32'(n_poll), 32'd8);
        chk("round_first_data", 32'(first_pdata), 32'h1A00);
        chk("round_last_data", 32'(last_pdata), 32'h1A07);

        // Only ports 1 and 3 present
        sfp_only_reg = 8'hF5;
        seen_ports.delete();
        snap_poll = n_poll;
        push_round(8'hF5, 0, 7);
        tick();
        run(2000);
        chk("f5_count", 32'(n_poll - snap_poll), 32'd2);
        if (seen_ports.size() == 2) begin
            chk("f5_port_a", 32'(seen_ports[0]), 32'd1);
            chk("f5_port_b", 32'(seen_ports[1]), 32'd3);
        end else begin
            chk("f5_seen", 32'(seen_ports.size()), 32'd2);
        end

        // CPU read of port 5 arriving during the port 2 poll
        sfp_only_reg = 8'h00;
        push_round(8'h00, 0, 2);
        exp_iss.push_back('{2'b10, 7'h50, 8'h00, 16'h0000, 8'h20});
        exp_cpu.push_back('{3'd5, 16'h1A05, 1'b0});
        push_round(8'h00, 3, 7);
        tick();
        wait_sel(8'h04, 500);
        cpu(3'd5, 2'b10, 7'h50, 8'h00, 16'h0000);
        run(2000);

        // Dead engine: start timeout; a second request while busy is dropped
        eng_dead = 1'b1;
        exp_iss.push_back('{2'b01, 7'h50, 8'h10, 16'hBEEF, 8'h08});
        exp_cpu.push_back('{3'd3, 16'h0000, 1'b1});
        cpu(3'd3, 2'b01, 7'h50, 8'h10, 16'hBEEF);
        cpu(3'd6, 2'b10, 7'h50, 8'h20, 16'h0000);
        run(500);
        chk("start_timeout_cycles", 32'(done_cyc - cmd_cyc), 32'd17);
        chk("sel_after_timeout", 32'(iic_sel), 32'd0);
        eng_dead = 1'b0;

        // Illegal command completes failed without touching the engine
        snap_cmd = n_cmd;
        exp_cpu.push_back('{3'd1, 16'h0000, 1'b1});
        cpu(3'd1, 2'b11, 7'h50, 8'h00, 16'h0000);
        run(200);
        chk("bad_cmd_no_issue", 32'(n_cmd - snap_cmd), 32'd0);

        // Reset during WAIT_DONE
        e_len = 40;
        exp_iss.push_back('{2'b10, 7'h51, 8'h60, 16'h0000, 8'h01});
        tick();
        wait_busy(200);
        repeat (3) @(negedge clk);
        snap_poll = n_poll;
        snap_cpu  = n_cpu;
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_cmd_sel", 32'({command, iic_sel}), 32'd0);
        chk("midrst_pulses", 32'({cpu_done, poll_valid}), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        chk("midrst_no_valid", 32'(n_poll - snap_poll), 32'd0);
        chk("midrst_no_done", 32'(n_cpu - snap_cpu), 32'd0);
        chk("midrst_iss_consumed", 32'(exp_iss.size()), 32'd0);
        chk("midrst_idle_sel", 32'(iic_sel), 32'd0);
        exp_iss.delete();
        e_len = 4;
        snap_poll = n_poll;
        push_round(8'h00, 0, 7);
        tick();
        run(2000);
        chk("restart_count", 32'(n_poll - snap_poll), 32'd8);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/sfp_iic_sched.md
SFP_IIC_SCHED -- requirements
Module: sfp_iic_sched

Interface
REQ-001 Parameters SHALL be: POLL_DEV 7'h51 (SFP diagnostic device ID); POLL_ADDR 8'h60 (temperature register); START_TO 16 (cycles allowed for busy to rise); DONE_TO 20'hFFFFF (cycles allowed for busy to fall).
REQ-002 The design SHALL use one clock and an asynchronous, active-low reset. Ports, listed as name, direction, width, meaning:
- clk  in  1  core clock.
- rst_n  in  1  asynchronous active-low reset.
REQ-003 The CPU-side ports SHALL be:
- cpu_req  in  1  one-cycle pulse requesting a CPU transaction.
- cpu_port  in  3  target SFP index.
- cpu_cmd  in  2  01 write, 10 read.
- cpu_dev_id  in  7  device ID.
- cpu_add  in  8  register address.
- cpu_wdata  in  16  write data.
- cpu_busy  out  1  CPU transaction pending or active.
- cpu_done  out  1  one-cycle completion pulse.
- cpu_fail  out  1  failure flag, valid with cpu_done.
- cpu_rdata  out  16  read data, valid with cpu_done.
REQ-004 The poll-side ports SHALL be:
- poll_tick  in  1  one-cycle pulse that starts a poll round (100 Hz domain, synchronous to clk).
- sfp_only_reg  in  8  debounced SFP absent flags, 1 = absent.
- poll_valid  out  1  one-cycle pulse marking a poll result.
- poll_port  out  3  index of the polled port.
- poll_data  out  16  temperature read from the port.
- poll_fail  out  1  poll transaction failed.
REQ-005 The I2C-engine ports SHALL be:
- command  out  2  00 idle, 01 write, 10 read; driven as a one-cycle pulse.
- dev_id  out  7  device ID.
- add  out  8  register address.
- data_out  out  16  write data.
- iic_sel  out  8  one-hot SCL lane select.
- busy  in  1  engine busy.
- fail  in  1  engine failure flag.
- data_in  in  16  engine read data.

Function
REQ-006 The FSM SHALL have five states: IDLE, ISSUE, WAIT_START, WAIT_DONE, COMPLETE.
REQ-007 In IDLE, a latched CPU request SHALL win over a pending poll port and the FSM SHALL go to ISSUE; an in-flight transaction SHALL never be preempted.
REQ-008 cpu_req SHALL be latched into a 1-deep pending register together with its fields.
- cpu_busy SHALL be set from the cycle after cpu_req until the cycle of cpu_done.
- cpu_req arriving while cpu_busy=1 SHALL be ignored.
REQ-009 On poll_tick, the poll pointer SHALL start at port 0 and the round SHALL be marked active.
- Ports whose sfp_only_reg bit is 1 at selection time SHALL be skipped, at one port per cycle, without any engine transaction.
- The round SHALL end after port 7.
- poll_tick during an active round SHALL be ignored.
REQ-010 A poll transaction SHALL be a read of POLL_DEV, POLL_ADDR. cmd=10 SHALL be issued with two_bytes set by the engine register; this block only supplies the address.
REQ-011 ISSUE SHALL last exactly one cycle:
- drive command, dev_id, add and data_out;
- set iic_sel to one-hot(port);
- go to WAIT_START.
REQ-012 In WAIT_START the FSM SHALL move to WAIT_DONE when busy=1. If busy is still 0 after START_TO cycles, it SHALL go to COMPLETE with fail forced to 1.
REQ-013 In WAIT_DONE the FSM SHALL move to COMPLETE on busy=0, sampling fail and data_in in that cycle. If DONE_TO cycles pass first, it SHALL go to COMPLETE with fail forced to 1.
REQ-014 COMPLETE SHALL last one cycle:
- pulse cpu_done or poll_valid (whichever owned the transaction) with the captured fail/data;
- advance the poll pointer if a poll owned it;
- return to IDLE.
REQ-015 iic_sel SHALL hold its one-hot value from ISSUE through COMPLETE and SHALL be 8'h00 in IDLE. command SHALL be 00 in every state except ISSUE.
REQ-016 A port becoming absent during its own transaction SHALL NOT abort it. The result SHALL still be reported.
REQ-017 A cpu_cmd of 00 or 11 SHALL complete in COMPLETE with cpu_fail=1 and no ISSUE.
REQ-018 Result outputs SHALL be registered, with a latency of 1 cycle from busy falling to the done/valid pulse.

Reset
REQ-019 On rst_n=0 the block SHALL asynchronously enter IDLE and clear every output to 0, including iic_sel=00 and command=00.
REQ-020 Reset SHALL also clear the pending CPU request, the poll round, the pointer and both timeout counters. Reset mid-transaction SHALL NOT produce a done or valid pulse.

Structure
REQ-021 State encodings, command codes (IDLE/WR/RD), POLL_DEV, POLL_ADDR, START_TO and DONE_TO SHALL live in shared package su51e8gf_pkg.
REQ-022 The block SHALL have one sub-module, sfp_poll_ptr, which holds the round-active flag and pointer and performs the absent-port skip.

Verification
REQ-023 The testbench SHALL cover these directed scenarios:
- All ports present, poll_tick, engine model returning data 16'h1A00+port → 8 poll_valid pulses, ports 0..7 in order, iic_sel 01,02,..,80.
- sfp_only_reg=8'hF5, poll_tick → poll_valid only for ports 1 and 3.
- cpu_req (port 5, read, 7'h50, 8'h00) issued during a port 2 poll → port 2 completes first, then the CPU transaction with iic_sel=8'h20, then the poll resumes at port 3.
- Engine never raises busy → cpu_done with cpu_fail=1 after 16 cycles, iic_sel back to 00.
- rst_n asserted in WAIT_DONE → command=00, iic_sel=00, no pulses; a fresh poll_tick then restarts from port 0.
- cpu_cmd=11 → cpu_done with cpu_fail=1 and no command issued.
